jtopl_acc_st: RTL and testbench
===============================

# jtopl_acc_st

Parametrised stereo successor to the OPL channel accumulator. Sums operator outputs over one frame of `SLOTS` operator slots, doubling rhythm slots, routing each term to left/right by per-slot pan enables. At each frame boundary it saturates and latches both channels and emits a one-cycle sample strobe. Sits between the operator pipeline and the DAC/resampler in OPL3-class designs.

## Interface
- `INW`, 13: signed operator result width.
- `OUTW`, 16: signed output sample width, `OUTW` ≥ `INW`+1.
- `SLOTS`, 18: operator slots per frame (≥2); `ACCW` = `INW`+1+clog2(`SLOTS`), internal.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cenop`  in  1  operator-rate clock enable; all state advances only when high.
- `zero`  in  1  marks the first slot of a frame (qualified by `cenop`).
- `op`  in  1  0 = modulator operator.
- `con`  in  1  0 = modulated connection.
- `rhy`  in  1  current slot is a rhythm slot (×2 gain).
- `pan_l`  in  1  add current term to left.
- `pan_r`  in  1  add current term to right.
- `op_result`  in  `INW`  signed operator output.
- `snd_l`  out  `OUTW`  signed left sample.
- `snd_r`  out  `OUTW`  signed right sample.
- `sample`  out  1  one-clk strobe, new samples valid.
- `clip`  out  2  {right,left} saturation occurred in the latched sample.
- `frame_err`  out  1  sticky: frame length ≠ `SLOTS`.

## Operation
- Term: `sum_en` = `op` | `con`; `t` = 0 if !`sum_en`, else `op_result` sign-extended to `INW`+1, shifted left 1 when `rhy`.
- Per-channel term: `tl` = `pan_l` ? `t` : 0; `tr` likewise.
- Slot counter `cnt` (clog2(`SLOTS`) bits), accumulators `acc_l`/`acc_r` (`ACCW` signed; wide enough that no internal overflow occurs).
- On `cenop` & !`zero`: `acc` += term; `cnt` += 1, saturating at `SLOTS`-1 (no wrap).
- On `cenop` & `zero` (frame boundary):
  - `snd_x` ← sat(`acc_x`) to [−2^(`OUTW`−1), 2^(`OUTW`−1)−1]; `clip[x]` ← 1 iff clamping applied.
  - `acc_x` ← current term (current slot counts toward the new frame); `cnt` ← 0.
  - `sample` ← 1.
  - `frame_err` ← 1 if `cnt` ≠ `SLOTS`−1 and a previous boundary was seen since reset (first boundary after reset never errors).
- `frame_err` clears only on reset.
- No `cenop`: all state holds; `sample` still clears.

## Timing
- Reset (async assert, sync-safe deassert): `snd_l`=`snd_r`=0, `sample`=0, `clip`=0, `frame_err`=0, accumulators 0, `cnt`=0, first-boundary flag cleared.
- `snd_x`/`clip` change only on the clk edge with `cenop`&`zero`; stable for the whole following frame.
- `sample` is registered: high for exactly one `clk` cycle after the boundary edge, aligned with new `snd_x`; deasserts at next edge regardless of `cenop`.
- Latency: last slot of frame N visible on `snd_x` one `cenop` later (at the frame N+1 boundary edge).
- Back-to-back `zero` on consecutive `cenop`: each latches; the second latches a one-term frame and flags `frame_err`.
- Reset mid-frame discards the partial sum; the next `zero` latches whatever has accumulated since reset, without error.

## Test plan
- Reset then 18-slot frame, all `op`=1, `pan_l`=`pan_r`=1, `op_result`=100, `rhy`=0 -> next boundary: `snd_l`=`snd_r`=1800, `sample` one cycle, `clip`=0.
- Same frame with `rhy`=1 on slots 13–18 -> `snd`=12·100+6·200=2400.
- `pan_l`=1, `pan_r`=0, `op`=0, `con`=0 on even slots, `op_result`=−50 -> `snd_l`=−450, `snd_r`=0.
- 18 slots `op_result`=4095, `rhy`=1 all slots -> raw 147420: `snd_l`=32767, `clip`=2'b11; repeat with −4096 -> −32768.
- `zero` after 10 slots (second frame) -> `frame_err`=1 and stays high through later correct frames until `rst_n` low.
- `cenop` low for 5 cycles mid-frame with changing `op_result` -> sum unaffected; `rst_n` pulse mid-frame -> all outputs 0 immediately, next frame sums from scratch.

Source files
------------

// File: rtl/jtopl_acc_st.sv
// Stereo OPL channel accumulator: sums one frame of operator
// slots per channel, then saturates and latches a sample pair.
module jtopl_acc_st #(
  parameter int INW   = 13,
  parameter int OUTW  = 16,
  parameter int SLOTS = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cenop,
  input  logic                   zero,
  input  logic                   op,
  input  logic                   con,
  input  logic                   rhy,
  input  logic                   pan_l,
  input  logic                   pan_r,
  input  logic signed [INW-1:0]  op_result,
  output logic signed [OUTW-1:0] snd_l,
  output logic signed [OUTW-1:0] snd_r,
  output logic                   sample,
  output logic [1:0]             clip,
  output logic                   frame_err
);

  localparam int CW   = $clog2(SLOTS);
  localparam int ACCW = INW + 1 + CW;
  localparam int XW   = (ACCW > OUTW) ? ACCW : OUTW;

  localparam logic [CW-1:0] LAST = CW'(SLOTS - 1);

  localparam logic signed [XW-1:0] SMAX =
    {{(XW-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN =
    {{(XW-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

  logic signed [INW:0]    t;
  logic signed [INW:0]    tl;
  logic signed [INW:0]    tr;
  logic signed [ACCW-1:0] tl_x;
  logic signed [ACCW-1:0] tr_x;
  logic signed [ACCW-1:0] acc_l;
  logic signed [ACCW-1:0] acc_r;
  logic [CW-1:0]          cnt;
  logic                   seen;
  logic signed [OUTW-1:0] sat_l;
  logic signed [OUTW-1:0] sat_r;
  logic                   clp_l;
  logic                   clp_r;

  // Clamp an accumulator to the output range, flagging clamping.
  function automatic logic [OUTW:0] sat(
    input logic signed [ACCW-1:0] a
  );
    logic signed [XW-1:0] x;
    x = XW'(a);
    if (x > SMAX)
      sat = {1'b1, SMAX[OUTW-1:0]};
    else if (x < SMIN)
      sat = {1'b1, SMIN[OUTW-1:0]};
    else
      sat = {1'b0, x[OUTW-1:0]};
  endfunction

  // Build the slot term and route it to each channel.
  always_comb begin
    t = '0;
    if (op | con) begin
      t = {op_result[INW-1], op_result};
      if (rhy)
        t = {t[INW-1:0], 1'b0};
    end
    tl   = pan_l ? t : '0;
    tr   = pan_r ? t : '0;
    tl_x = {{(ACCW-INW-1){tl[INW]}}, tl};
    tr_x = {{(ACCW-INW-1){tr[INW]}}, tr};
    {clp_l, sat_l} = sat(acc_l);
    {clp_r, sat_r} = sat(acc_r);
  end

  // Accumulate slots; latch saturated samples at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_l     <= '0;
      acc_r     <= '0;
      cnt       <= '0;
      seen      <= 1'b0;
      snd_l     <= '0;
      snd_r     <= '0;
      sample    <= 1'b0;
      clip      <= 2'b00;
      frame_err <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cenop) begin
        if (zero) begin
          snd_l  <= sat_l;
          snd_r  <= sat_r;
          clip   <= {clp_r, clp_l};
          acc_l  <= tl_x;
          acc_r  <= tr_x;
          cnt    <= '0;
          sample <= 1'b1;
          seen   <= 1'b1;
          if (seen && cnt != LAST)
            frame_err <= 1'b1;
        end else begin
          acc_l <= acc_l + tl_x;
          acc_r <= acc_r + tr_x;
          if (cnt != LAST)
            cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtopl_acc_st.sv
// Directed-vector bench for jtopl_acc_st: frame sums, rhythm
// gain, panning, saturation, frame errors, cenop gaps, reset.
module tb_jtopl_acc_st;

  logic               clk;
  logic               rst_n;
  logic               cenop;
  logic               zero;
  logic               op;
  logic               con;
  logic               rhy;
  logic               pan_l;
  logic               pan_r;
  logic signed [12:0] op_result;
  logic signed [15:0] snd_l;
  logic signed [15:0] snd_r;
  logic               sample;
  logic [1:0]         clip;
  logic               frame_err;

  int nvec;
  int nbad;

  jtopl_acc_st #(
    .INW  (13),
    .OUTW (16),
    .SLOTS(18)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cenop    (cenop),
    .zero     (zero),
    .op       (op),
    .con      (con),
    .rhy      (rhy),
    .pan_l    (pan_l),
    .pan_r    (pan_r),
    .op_result(op_result),
    .snd_l    (snd_l),
    .snd_r    (snd_r),
    .sample   (sample),
    .clip     (clip),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic slot(
    input logic z, input logic o, input logic c, input logic r,
    input logic pl, input logic pr, input logic signed [12:0] v
  );
    cenop     = 1'b1;
    zero      = z;
    op        = o;
    con       = c;
    rhy       = r;
    pan_l     = pl;
    pan_r     = pr;
    op_result = v;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 base 100, 1 rhythm on slots 13-18, 2 left-only -50
  // on odd slots via con, 3 +4095 x2, 4 -4096 x2, 5 base with a
  // cenop gap, 6 base without a boundary slot.
  // The expected values describe the frame latched at its start.
  task automatic frame(
    input int mode, input int n, input bit en,
    input int el, input int er, input int ec, input int ee
  );
    logic z, o, c, r, pl, pr;
    logic signed [12:0] v;
    for (int i = 0; i < n; i++) begin
      z = (i == 0) && (mode != 6);
      o = 1'b1; c = 1'b0; r = 1'b0;
      pl = 1'b1; pr = 1'b1; v = 13'sd100;
      case (mode)
        1: r = (i >= 12);
        2: begin
          pr = 1'b0; v = -13'sd50;
          o = 1'b0; c = (i % 2 == 0);
        end
        3: begin r = 1'b1; v = 13'sd4095; end
        4: begin r = 1'b1; v = -13'sd4096; end
        default: ;
      endcase
      if (mode == 5 && i == 8) begin
        cenop = 1'b0;
        zero  = 1'b1;
        for (int j = 0; j < 5; j++) begin
          op_result = 13'(j * 777 + 11);
          rhy       = j[0];
          @(posedge clk);
          #1;
          chk("gap_sample", int'(sample), 0);
        end
      end
      slot(z, o, c, r, pl, pr, v);
      if (en && i == 0) begin
        chk("snd_l", int'(snd_l), el);
        chk("snd_r", int'(snd_r), er);
        chk("clip", int'(clip), ec);
        chk("frame_err", int'(frame_err), ee);
        chk("sample_hi", int'(sample), 1);
      end
      if (en && i == 1)
        chk("sample_lo", int'(sample), 0);
    end
  endtask

  initial begin
    nvec = 0;
    nbad = 0;
    rst_n = 1'b0;
    cenop = 1'b0; zero = 1'b0; op = 1'b0; con = 1'b0;
    rhy = 1'b0; pan_l = 1'b0; pan_r = 1'b0; op_result = '0;
    #13;
    chk("rst_snd_l", int'(snd_l), 0);
    chk("rst_snd_r", int'(snd_r), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_ferr", int'(frame_err), 0);
    #10;
    rst_n = 1'b1;

    frame(0, 18, 1'b1, 0, 0, 0, 0);
    frame(1, 18, 1'b1, 1800, 1800, 0, 0);
    frame(2, 18, 1'b1, 2400, 2400, 0, 0);
    frame(3, 18, 1'b1, -450, 0, 0, 0);
    frame(4, 18, 1'b1, 32767, 32767, 3, 0);
    frame(0, 10, 1'b1, -32768, -32768, 3, 0);
    frame(0, 18, 1'b1, 1000, 1000, 0, 1);
    frame(5, 18, 1'b1, 1800, 1800, 0, 1);
    frame(0, 7, 1'b1, 1800, 1800, 0, 1);

    rst_n = 1'b0;
    #2;
    chk("mid_rst_snd_l", int'(snd_l), 0);
    chk("mid_rst_snd_r", int'(snd_r), 0);
    chk("mid_rst_sample", int'(sample), 0);
    chk("mid_rst_clip", int'(clip), 0);
    chk("mid_rst_ferr", int'(frame_err), 0);
    #2;
    rst_n = 1'b1;

    frame(6, 5, 1'b0, 0, 0, 0, 0);
    frame(0, 18, 1'b1, 500, 500, 0, 0);
    frame(0, 1, 1'b1, 1800, 1800, 0, 0);
    frame(0, 1, 1'b1, 100, 100, 0, 1);
    frame(0, 18, 1'b1, 100, 100, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
